// File: rtl/alu_srcb_if.sv
// alu_srcb_if: bundles the ALU source-B stage's upstream beat, forwarding sources and downstream beat
//   master: drives in_* / flush / fw1_* / fw2_* / out_ready, observes in_ready / out_* / fwd_cnt
//   slave : the stage itself (mirror of master)
interface alu_srcb_if #(
    parameter int WIDTH   = 32,
    parameter int REGADDR = 5,
    parameter int IMMW    = 16
);
    logic               in_valid;
    logic               in_ready;
    logic               in_alusrcb;
    logic [1:0]         in_immmode;
    logic [IMMW-1:0]    in_imm;
    logic [WIDTH-1:0]   in_b;
    logic [REGADDR-1:0] in_rs2;
    logic               flush;
    logic               fw1_we;
    logic [REGADDR-1:0] fw1_rd;
    logic [WIDTH-1:0]   fw1_data;
    logic               fw2_we;
    logic [REGADDR-1:0] fw2_rd;
    logic [WIDTH-1:0]   fw2_data;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_srcb;
    logic [WIDTH-1:0]   out_b;
    logic [15:0]        fwd_cnt;
    modport master (
        output in_valid, in_alusrcb, in_immmode, in_imm, in_b, in_rs2, flush,
               fw1_we, fw1_rd, fw1_data, fw2_we, fw2_rd, fw2_data, out_ready,
        input  in_ready, out_valid, out_srcb, out_b, fwd_cnt
    );
    modport slave (
        input  in_valid, in_alusrcb, in_immmode, in_imm, in_b, in_rs2, flush,
               fw1_we, fw1_rd, fw1_data, fw2_we, fw2_rd, fw2_data, out_ready,
        output in_ready, out_valid, out_srcb, out_b, fwd_cnt
    );
endinterface

// File: rtl/alu_srcb_stage.sv
// alu_srcb_stage: ALU operand-B stage -- forwards onto rs2, extends the immediate, registers srcb/store data
//   clk, rst_n (async active-low), bus (alu_srcb_if.slave): upstream ready/valid beat with flush,
//   EX/MEM (fw1) and MEM/WB (fw2) writeback ports, downstream ready/valid srcb/b, fwd_cnt
//   SRCB_FWD_EN: when defined, enables the forwarding network and fwd_cnt; otherwise fb = in_b, fwd_cnt = 0
module alu_srcb_stage #(
    parameter int WIDTH   = 32,
    parameter int REGADDR = 5,
    parameter int IMMW    = 16
) (
    input logic        clk,
    input logic        rst_n,
    alu_srcb_if.slave  bus
);
    localparam int PAD = WIDTH - IMMW;
    logic [WIDTH-1:0] sx, zx, up, ext, fb, srcb;
    logic             fwd_hit, accept;
    assign sx = {{PAD{bus.in_imm[IMMW-1]}}, bus.in_imm};
    assign zx = {{PAD{1'b0}}, bus.in_imm};
    assign up = {bus.in_imm, {PAD{1'b0}}};
    assign ext = bus.in_immmode[1] ? (bus.in_immmode[0] ? '0 : up) : (bus.in_immmode[0] ? zx : sx);
`ifdef SRCB_FWD_EN
    logic hit1, hit2;
    // x0 is hardwired zero, so a writeback naming it never forwards
    assign hit1 = bus.fw1_we && bus.fw1_rd == bus.in_rs2 && bus.in_rs2 != '0;
    assign hit2 = bus.fw2_we && bus.fw2_rd == bus.in_rs2 && bus.in_rs2 != '0;
    assign fb = hit1 ? bus.fw1_data : hit2 ? bus.fw2_data : bus.in_b;
    assign fwd_hit = hit1 || hit2;
`else
    assign fb = bus.in_b;
    assign fwd_hit = 1'b0;
`endif
    assign srcb = bus.in_alusrcb ? ext : fb;
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept = bus.in_valid && bus.in_ready && !bus.flush;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_srcb  <= '0;
            bus.out_b     <= '0;
        end else begin
            // a held beat survives only while stalled and not flushed
            bus.out_valid <= accept || (bus.out_valid && !bus.out_ready && !bus.flush);
            if (accept) begin
                bus.out_srcb <= srcb;
                bus.out_b    <= fb;
            end
        end
    end
`ifdef SRCB_FWD_EN
    logic [15:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (accept && fwd_hit && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
    assign bus.fwd_cnt = cnt;
`else
    assign bus.fwd_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_alu_srcb_stage.sv
// tb_alu_srcb_stage: directed self-checking bench for alu_srcb_stage (expectations follow SRCB_FWD_EN)
module tb_alu_srcb_stage;
`ifdef SRCB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_cnt = 16'd0;
    alu_srcb_if #(.WIDTH(32), .REGADDR(5), .IMMW(16)) bus ();
    alu_srcb_stage #(.WIDTH(32), .REGADDR(5), .IMMW(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0; bus.in_alusrcb = 1'b0; bus.in_immmode = 2'b00; bus.in_imm = '0;
        bus.in_b = '0; bus.in_rs2 = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;
        bus.fw1_we = 1'b0; bus.fw1_rd = '0; bus.fw1_data = '0;
        bus.fw2_we = 1'b0; bus.fw2_rd = '0; bus.fw2_data = '0;
    endtask

    task automatic test_reset();
        idle();
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_b = 32'h99; bus.in_alusrcb = 1'b1;
        bus.in_imm = 16'h1234;
        tick();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_b !== 32'h99) begin
            miscompares++;
            $display("FAIL reset_preload: valid=%b b=%h want 1 00000099", bus.out_valid, bus.out_b);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        vectors++;
        if (bus.out_srcb !== 32'h0) begin miscompares++; $display("FAIL reset_srcb: got %h want 0", bus.out_srcb); end
        vectors++;
        if (bus.out_b !== 32'h0) begin miscompares++; $display("FAIL reset_b: got %h want 0", bus.out_b); end
        vectors++;
        if (bus.fwd_cnt !== 16'h0) begin miscompares++; $display("FAIL reset_cnt: got %h want 0", bus.fwd_cnt); end
        vectors++;
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", bus.in_ready); end
        tick();
        idle();
        rst_n = 1'b1;
        exp_cnt = 16'd0;
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_after: valid=%b ready=%b want 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_imm_modes();
        logic [31:0] exp [4] = '{32'hFFFF8001, 32'h00008001, 32'h80010000, 32'h00000000};
        idle();
        bus.in_valid = 1'b1; bus.in_alusrcb = 1'b1; bus.in_imm = 16'h8001; bus.in_b = 32'h1234;
        for (int m = 0; m < 4; m++) begin
            bus.in_immmode = 2'(m);
            tick();
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_srcb !== exp[m]) begin
                miscompares++;
                $display("FAIL imm_mode%0d: valid=%b srcb=%h want 1 %h", m, bus.out_valid, bus.out_srcb, exp[m]);
            end
            vectors++;
            if (bus.out_b !== 32'h1234) begin
                miscompares++;
                $display("FAIL imm_b%0d: got %h want 00001234", m, bus.out_b);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_forwarding();
        idle();
        bus.in_valid = 1'b1; bus.in_rs2 = 5'd5; bus.in_b = 32'h11;
        bus.fw1_we = 1'b1; bus.fw1_rd = 5'd5; bus.fw1_data = 32'hAA;
        bus.fw2_we = 1'b1; bus.fw2_rd = 5'd5; bus.fw2_data = 32'hBB;
        tick();
        if (FWD) exp_cnt++;
        vectors++;
        if (bus.out_b !== (FWD ? 32'hAA : 32'h11) || bus.out_srcb !== bus.out_b) begin
            miscompares++;
            $display("FAIL fwd_fw1: b=%h srcb=%h want %h", bus.out_b, bus.out_srcb, FWD ? 32'hAA : 32'h11);
        end
        bus.fw1_we = 1'b0;
        tick();
        if (FWD) exp_cnt++;
        vectors++;
        if (bus.out_b !== (FWD ? 32'hBB : 32'h11)) begin
            miscompares++;
            $display("FAIL fwd_fw2: got %h want %h", bus.out_b, FWD ? 32'hBB : 32'h11);
        end
        bus.in_rs2 = 5'd0; bus.fw1_we = 1'b1; bus.fw1_rd = 5'd0; bus.fw2_rd = 5'd0;
        tick();
        vectors++;
        if (bus.out_b !== 32'h11) begin
            miscompares++;
            $display("FAIL fwd_x0: got %h want 00000011", bus.out_b);
        end
        bus.in_alusrcb = 1'b1; bus.in_immmode = 2'b01; bus.in_imm = 16'h0042; bus.in_rs2 = 5'd5;
        bus.fw1_rd = 5'd5;
        tick();
        if (FWD) exp_cnt++;
        vectors++;
        if (bus.out_srcb !== 32'h42 || bus.out_b !== (FWD ? 32'hAA : 32'h11)) begin
            miscompares++;
            $display("FAIL fwd_imm: srcb=%h b=%h want 00000042 %h", bus.out_srcb, bus.out_b, FWD ? 32'hAA : 32'h11);
        end
        vectors++;
        if (bus.fwd_cnt !== exp_cnt) begin
            miscompares++;
            $display("FAIL fwd_cnt: got %h want %h", bus.fwd_cnt, exp_cnt);
        end
        idle();
        tick();
    endtask

    task automatic test_backpressure();
        idle();
        bus.in_valid = 1'b1; bus.in_b = 32'd100;
        tick();
        bus.out_ready = 1'b0; bus.in_b = 32'd101;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_b !== 32'd100) begin
                miscompares++;
                $display("FAIL bp_stall%0d: ready=%b valid=%b b=%0d want 0 1 100", i, bus.in_ready, bus.out_valid, bus.out_b);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_b !== 32'd101) begin
            miscompares++;
            $display("FAIL bp_release: valid=%b b=%0d want 1 101", bus.out_valid, bus.out_b);
        end
        for (int i = 0; i < 8; i++) begin
            bus.in_b = 32'(200 + i);
            tick();
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_b !== 32'(200 + i) || bus.in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_stream%0d: valid=%b b=%0d ready=%b want 1 %0d 1", i, bus.out_valid, bus.out_b, bus.in_ready, 200 + i);
            end
        end
        bus.in_valid = 1'b0;
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_b !== 32'd207) begin
            miscompares++;
            $display("FAIL bp_drain: valid=%b b=%0d want 0 207", bus.out_valid, bus.out_b);
        end
    endtask

    task automatic test_flush();
        idle();
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_b = 32'h300;
        tick();
        bus.flush = 1'b1; bus.in_b = 32'h400; bus.in_rs2 = 5'd5;
        bus.fw1_we = 1'b1; bus.fw1_rd = 5'd5; bus.fw1_data = 32'h500;
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_b !== 32'h300) begin
            miscompares++;
            $display("FAIL flush_held: valid=%b b=%h want 0 00000300", bus.out_valid, bus.out_b);
        end
        bus.out_ready = 1'b1;
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_b !== 32'h300) begin
            miscompares++;
            $display("FAIL flush_open: valid=%b b=%h want 0 00000300", bus.out_valid, bus.out_b);
        end
        vectors++;
        if (bus.fwd_cnt !== exp_cnt) begin
            miscompares++;
            $display("FAIL flush_cnt: got %h want %h", bus.fwd_cnt, exp_cnt);
        end
        idle();
        tick();
    endtask

    task automatic test_saturation();
        int n = FWD ? 65536 - 2 - int'(exp_cnt) : 4;
        idle();
        bus.in_valid = 1'b1; bus.in_rs2 = 5'd7; bus.in_b = 32'h55;
        bus.fw1_we = 1'b1; bus.fw1_rd = 5'd7; bus.fw1_data = 32'h77;
        repeat (n) @(posedge clk);
        #1;
        vectors++;
        if (bus.fwd_cnt !== (FWD ? 16'hFFFE : 16'h0)) begin
            miscompares++;
            $display("FAIL sat_pre: got %h want %h", bus.fwd_cnt, FWD ? 16'hFFFE : 16'h0);
        end
        tick();
        vectors++;
        if (bus.fwd_cnt !== (FWD ? 16'hFFFF : 16'h0)) begin
            miscompares++;
            $display("FAIL sat_max: got %h want %h", bus.fwd_cnt, FWD ? 16'hFFFF : 16'h0);
        end
        tick();
        vectors++;
        if (bus.fwd_cnt !== (FWD ? 16'hFFFF : 16'h0)) begin
            miscompares++;
            $display("FAIL sat_hold: got %h want %h", bus.fwd_cnt, FWD ? 16'hFFFF : 16'h0);
        end
        vectors++;
        if (bus.out_b !== (FWD ? 32'h77 : 32'h55)) begin
            miscompares++;
            $display("FAIL sat_b: got %h want %h", bus.out_b, FWD ? 32'h77 : 32'h55);
        end
        idle();
        tick();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) tick();
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.fwd_cnt !== 16'h0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL por: valid=%b cnt=%h ready=%b want 0 0000 1", bus.out_valid, bus.fwd_cnt, bus.in_ready);
        end
        rst_n = 1'b1;
        tick();
        test_reset();
        test_imm_modes();
        test_forwarding();
        test_backpressure();
        test_flush();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
